// File: rtl/joy_serializer_neptuno_if.sv
// Serial joystick bus between a board decoder (master) and the
// shift-register responder (slave).
interface joy_serializer_neptuno_if;
   logic joy_clk_i;
   logic joy_load_i;
   logic joy_data_o;

   modport master (
      output joy_clk_i,
      output joy_load_i,
      input  joy_data_o
   );

   modport slave (
      input  joy_clk_i,
      input  joy_load_i,
      output joy_data_o
   );
endinterface

// File: rtl/joy_serializer_neptuno.sv
// Parallel-in/serial-out joystick register emulation with frame,
// overrun and link-loss status.
module joy_serializer_neptuno #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic        FILL_BIT       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            joy1_i,
   input  logic [5:0]            joy2_i,
   joy_serializer_neptuno_if.slave joy,
   output logic                  frame_done_o,
   output logic                  overrun_o,
   output logic                  link_lost_o,
   output logic [7:0]            frame_count_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

   logic [2:0]    clk_sync;
   logic [2:0]    load_sync;
   logic          clk_rise;
   logic          load_rise;
   logic          load_n;
   logic [15:0]   frame;
   logic [15:0]   sr;
   logic [4:0]    bit_cnt;
   logic [TW-1:0] t_cnt;

   assign clk_rise  = clk_sync[1] & ~clk_sync[2];
   assign load_rise = load_sync[1] & ~load_sync[2];
   assign load_n    = load_sync[1];

   // Buttons go out in reverse port order: up first, fire2 last.
   assign frame = {
      joy1_i[0], joy1_i[1], joy1_i[2],
      joy1_i[3], joy1_i[4], joy1_i[5],
      2'b11,
      joy2_i[0], joy2_i[1], joy2_i[2],
      joy2_i[3], joy2_i[4], joy2_i[5],
      2'b11
   };

   assign joy.joy_data_o = sr[15];
   assign link_lost_o    = (t_cnt == T_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 3'b111;
         load_sync <= 3'b111;
      end else begin
         clk_sync  <= {clk_sync[1:0], joy.joy_clk_i};
         load_sync <= {load_sync[1:0], joy.joy_load_i};
      end
   end

   // Load dominates a coincident shift clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr            <= 16'hFFFF;
         bit_cnt       <= '0;
         frame_done_o  <= 1'b0;
         overrun_o     <= 1'b0;
         frame_count_o <= '0;
      end else begin
         frame_done_o <= 1'b0;
         if (!load_n) begin
            sr        <= frame;
            bit_cnt   <= '0;
            overrun_o <= 1'b0;
         end else if (clk_rise) begin
            sr <= {sr[14:0], FILL_BIT};
            if (bit_cnt == 5'd16) begin
               overrun_o <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
            if (bit_cnt == 5'd15) begin
               frame_done_o  <= 1'b1;
               frame_count_o <= frame_count_o + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t_cnt <= '0;
      end else if (load_rise) begin
         t_cnt <= '0;
      end else if (t_cnt != T_MAX) begin
         t_cnt <= t_cnt + 1'b1;
      end
   end

endmodule
